// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic single-access initiator behind a valid/ready command/response port
// Ports: io_wbs_clk/io_wbs_rst clock and synchronous active-high reset;
//        cmd_* command in (valid/ready); rsp_* response out (valid/ready);
//        busy/err_count status; io_wbm_* Wishbone classic initiator bus.
module wb_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                     io_wbs_clk,
    input  logic                     io_wbs_rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [31:0]              cmd_adr,
    input  logic [31:0]              cmd_dat,
    input  logic [3:0]               cmd_sel,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_dat,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [31:0]              io_wbm_adr,
    output logic [31:0]              io_wbm_datwr,
    input  logic [31:0]              io_wbm_datrd,
    output logic                     io_wbm_we,
    output logic [3:0]               io_wbm_sel,
    output logic                     io_wbm_stb,
    input  logic                     io_wbm_ack,
    output logic                     io_wbm_cyc
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    state_t                   state_q, state_d;
    logic [15:0]              tmo_q, tmo_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [31:0]              rsp_dat_q, rsp_dat_d;
    logic                     rsp_err_q, rsp_err_d;
    logic                     busy_q, busy_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                     stb_q, stb_d;
    logic                     we_q, we_d;
    logic [31:0]              adr_q, adr_d;
    logic [31:0]              datwr_q, datwr_d;
    logic [3:0]               sel_q, sel_d;
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        datwr_d     = datwr_q;
        sel_d       = sel_q;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready_q) begin
                state_d = BUS;
                stb_d   = 1'b1;
                we_d    = cmd_we;
                adr_d   = cmd_adr;
                datwr_d = cmd_dat;
                sel_d   = cmd_sel;
                tmo_d   = '0;
            end
            BUS: if (io_wbm_ack) begin
                // an ack in the last timeout cycle still completes normally
                state_d     = RESP;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_dat_d   = we_q ? '0 : io_wbm_datrd;
                rsp_err_d   = 1'b0;
            end else if (tmo_q == TMO_LAST) begin
                state_d     = RESP;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_dat_d   = '0;
                rsp_err_d   = 1'b1;
                err_count_d = &err_count_q ? err_count_q : err_count_q + ERR_CNT_WIDTH'(1);
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
            RESP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = state_d == IDLE;
        busy_d      = state_d != IDLE;
    end
    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_count_q <= '0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            datwr_q     <= '0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            err_count_q <= err_count_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            datwr_q     <= datwr_d;
            sel_q       <= sel_d;
        end
    end
    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_dat      = rsp_dat_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = busy_q;
    assign err_count    = err_count_q;
    assign io_wbm_adr   = adr_q;
    assign io_wbm_datwr = datwr_q;
    assign io_wbm_we    = we_q;
    assign io_wbm_sel   = sel_q;
    assign io_wbm_stb   = stb_q;
    assign io_wbm_cyc   = stb_q;
endmodule
